// File: rtl/agn_shape.sv
// Pulse shape generator: bursts of parabola/triangle/rectangle/sawtooth pulses,
// scaled by ka*m, shifted down and clipped to the output width.
module agn_shape #(
  parameter int NPW = 10,
  parameter int RW  = 16,
  parameter int MW  = 8,
  parameter int OW  = 12,
  parameter int SH  = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           start,
  input  logic           stop,
  input  logic [NPW-1:0] np,
  input  logic [1:0]     mode,
  input  logic [7:0]     nburst,
  input  logic [15:0]    ka,
  input  logic [MW-1:0]  m,
  output logic           busy,
  output logic           co,
  output logic           done,
  output logic           sat,
  output logic [OW-1:0]  out
);

  localparam int PW = RW + 16 + MW;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state, state_nx;
  logic [NPW-1:0]        npe_q, idx, idx_nx;
  logic [1:0]            mode_q;
  logic [7:0]            nburst_q, cnt, cnt_nx;
  logic [15:0]           ka_q;
  logic [MW-1:0]         m_q;
  logic [RW-1:0]         para, para_nx;
  logic signed [RW-1:0]  slope, slope_nx;
  logic                  done_q, done_nx, load;

  logic [NPW-1:0]        np_even, npe_in, rev;
  logic                  last, final_pulse;
  logic [RW-1:0]         raw;
  logic [PW-1:0]         prod, scaled;
  logic                  ovf;

  // Odd point counts are rounded down so the parabola recurrence stays exact.
  assign np_even     = {np[NPW-1:1], 1'b0};
  assign npe_in      = (np_even < NPW'(4)) ? NPW'(4) : np_even;
  assign last        = (idx == npe_q - NPW'(1));
  assign final_pulse = (nburst_q != 8'd0) && (cnt + 8'd1 == nburst_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      para     <= '0;
      slope    <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      npe_q    <= '0;
      mode_q   <= '0;
      nburst_q <= '0;
      ka_q     <= '0;
      m_q      <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      para   <= para_nx;
      slope  <= slope_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
      if (load) begin
        npe_q    <= npe_in;
        mode_q   <= mode;
        nburst_q <= nburst;
        ka_q     <= ka;
        m_q      <= m;
      end
    end
  end

  // A stop seen on the last point of a pulse ends the burst on that same edge.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    para_nx  = para;
    slope_nx = slope;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    load     = 1'b0;
    if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            load     = 1'b1;
            idx_nx   = '0;
            para_nx  = '0;
            cnt_nx   = '0;
            slope_nx = $signed(RW'(npe_in >> 1) - RW'(1));
          end
        end
        RUN, FIN: begin
          if (last) begin
            idx_nx   = '0;
            para_nx  = '0;
            slope_nx = $signed(RW'(npe_q >> 1) - RW'(1));
            cnt_nx   = cnt + 8'd1;
            if (state == FIN || stop || final_pulse) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            idx_nx   = idx + NPW'(1);
            para_nx  = para + $unsigned(slope);
            slope_nx = slope - RW'(1);
            if (state == RUN && stop) state_nx = FIN;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign rev = npe_q - NPW'(1) - idx;

  always_comb begin
    case (mode_q)
      2'd0:    raw = para;
      2'd1:    raw = (idx < rev) ? RW'(idx) : RW'(rev);
      2'd2:    raw = RW'(npe_q >> 1);
      default: raw = RW'(idx);
    endcase
  end

  assign prod   = PW'(raw) * PW'(ka_q) * PW'(m_q);
  assign scaled = prod >> SH;
  assign ovf    = |scaled[PW-1:OW];

  assign busy = (state != IDLE);
  assign co   = busy && last;
  assign done = done_q;
  assign sat  = busy && ovf;
  assign out  = !busy ? '0 : (ovf ? '1 : scaled[OW-1:0]);

endmodule

// File: tb/tb_agn_shape.sv
// Self-checking bench for agn_shape: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a closed-form model.
module tb_agn_shape;

  logic        clk = 1'b0;
  logic        rst_n, ce, start, stop;
  logic [9:0]  np;
  logic [1:0]  mode;
  logic [7:0]  nburst;
  logic [15:0] ka;
  logic [7:0]  m;
  logic        busy, co, done, sat;
  logic [11:0] out;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  agn_shape dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .stop(stop),
    .np(np), .mode(mode), .nburst(nburst), .ka(ka), .m(m),
    .busy(busy), .co(co), .done(done), .sat(sat), .out(out)
  );

  // Reference model: burst position as plain integers
  bit mb, mf, md;
  int mi, mc, mnpe, mmode, mnb, mka, mm;

  always @(posedge clk) begin
    md = 1'b0;
    if (rst_n !== 1'b1) begin
      mb = 1'b0; mf = 1'b0; mi = 0; mc = 0;
    end else if (ce) begin
      if (!mb) begin
        if (start) begin
          mb = 1'b1; mf = 1'b0; mi = 0; mc = 0;
          mnpe = int'(np) & ~1;
          if (mnpe < 4) mnpe = 4;
          mmode = int'(mode); mnb = int'(nburst); mka = int'(ka); mm = int'(m);
        end
      end else if (mi == mnpe - 1) begin
        mi = 0;
        mc++;
        if (mf || stop || (mnb != 0 && mc == mnb)) begin
          mb = 1'b0;
          md = 1'b1;
        end
      end else begin
        mi++;
        if (stop) mf = 1'b1;
      end
    end
  end

  function automatic int shapeRaw(input int md_, input int i, input int n);
    case (md_)
      0:       return i * (n - 1 - i) / 2;
      1:       return (i < n - 1 - i) ? i : n - 1 - i;
      2:       return n / 2;
      default: return i;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of {busy,co,done,sat,out} against the model
  always @(negedge clk) begin
    if (chk_en) begin
      longint s;
      logic [15:0] e;
      logic esat;
      logic [11:0] eout;
      esat = 1'b0;
      eout = '0;
      if (mb) begin
        s = (longint'(shapeRaw(mmode, mi, mnpe)) * mka * mm) >> 18;
        esat = (s > 4095);
        eout = esat ? 12'hFFF : 12'(s);
      end
      e = {mb, (mb && mi == mnpe - 1), md, esat, eout};
      checkOutput("cycle", {16'h0, busy, co, done, sat, out}, {16'h0, e});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [9:0] n, input logic [1:0] md_, input logic [7:0] nb,
                               input logic [15:0] k, input logic [7:0] mul);
    np = n; mode = md_; nburst = nb; ka = k; m = mul;
  endtask

  task automatic startBurst();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  int tri_exp[6] = '{0, 1, 2, 2, 1, 0};
  int done_seen;

  initial begin
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; stop = 1'b0;
    applyStimulus(10'd100, 2'd0, 8'd1, 16'd6687, 8'd128);
    tick(3);
    chk_en = 1'b1;
    checkOutput("reset_state", {busy, co, done, sat, out}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Nominal parabola burst
    startBurst();
    checkOutput("p_idx0_out", out, 0);
    tick(49);
    checkOutput("p_idx49_out", out, 3999);
    tick(1);
    checkOutput("p_idx50_out", out, 3999);
    tick(49);
    checkOutput("p_idx99_co", {busy, co}, 2'b11);
    tick(1);
    checkOutput("p_done", {busy, done}, 2'b01);
    tick(1);
    checkOutput("p_done_low", done, 0);

    // Saturating gain
    applyStimulus(10'd100, 2'd0, 8'd1, 16'd65535, 8'd255);
    startBurst();
    checkOutput("sat_idx0", {sat, out}, 0);
    tick(49);
    checkOutput("sat_peak", {sat, out}, 13'h1FFF);
    waitIdle(200);

    // Odd np rounds down; triangle at npe=6 with unity gain
    applyStimulus(10'd7, 2'd1, 8'd1, 16'd2048, 8'd128);
    startBurst();
    for (int i = 0; i < 6; i++) begin
      checkOutput("tri_seq", out, tri_exp[i]);
      if (i == 5) checkOutput("tri_co", co, 1);
      tick(1);
    end
    checkOutput("tri_done", done, 1);

    // np=2 clamps to npe=4, sawtooth, two pulses
    applyStimulus(10'd2, 2'd3, 8'd2, 16'd2048, 8'd128);
    tick(1);
    startBurst();
    tick(3);
    checkOutput("np2_idx3", {co, out}, 13'h1003);
    tick(4);
    checkOutput("np2_co2", {busy, co}, 2'b11);
    tick(1);
    checkOutput("np2_done", done, 1);

    // Continuous burst ended by stop; start during FIN ignored
    applyStimulus(10'd100, 2'd0, 8'd0, 16'd6687, 8'd128);
    tick(1);
    startBurst();
    tick(230);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(67);
    checkOutput("stop_last", {busy, co}, 2'b11);
    tick(1);
    checkOutput("stop_done", {busy, done}, 2'b01);
    tick(1);
    checkOutput("stop_done_low", {busy, done}, 2'b00);

    // Half-rate enable: done still one clock wide
    applyStimulus(10'd12, 2'd1, 8'd1, 16'd2048, 8'd128);
    startBurst();
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      ce = ~ce;
      tick(1);
      if (done) done_seen++;
    end
    ce = 1'b1;
    checkOutput("halfrate_done_width", done_seen, 1);

    // Reset mid-burst, then a fresh burst
    applyStimulus(10'd100, 2'd0, 8'd1, 16'd6687, 8'd128);
    startBurst();
    tick(40);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midreset_zero", {busy, co, done, sat, out}, 32'h0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("midreset_nodone", {busy, done}, 2'b00);
    startBurst();
    checkOutput("re_idx0", out, 0);
    tick(49);
    checkOutput("re_peak", out, 3999);
    tick(50);
    checkOutput("re_co", co, 1);
    tick(1);
    checkOutput("re_done", done, 1);

    // Randomized traffic, model checked every cycle
    for (int c = 0; c < 6000; c++) begin
      rst_n  = ($urandom % 800) != 0;
      ce     = ($urandom % 4) != 0;
      start  = ($urandom % 6) == 0;
      stop   = ($urandom % 80) == 0;
      np     = 10'($urandom_range(0, 200));
      mode   = 2'($urandom);
      nburst = 8'($urandom % 4);
      ka     = ($urandom % 2) ? 16'($urandom % 4096) : 16'($urandom);
      m      = 8'($urandom);
      tick(1);
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; ce = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/agn_shape.md
AGN_SHAPE -- requirements
Module: agn_shape

Interface
REQ-001 Parameter NPW, default 10: width of point counter and of np input.
REQ-002 Parameter RW, default 16: width of raw shape accumulator.
REQ-003 Parameter MW, default 8: width of amplitude multiplier m.
REQ-004 Parameter OW, default 12: width of output sample.
REQ-005 Parameter SH, default 18: right shift applied to the scaled product.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ce  in  1  step enable; state advances only on edges with ce=1.
REQ-009 start  in  1  request to begin a burst, sampled when idle and ce=1.
REQ-010 stop  in  1  request to end after the current pulse, sampled when ce=1.
REQ-011 np  in  NPW  points per pulse.
REQ-012 mode  in  2  shape: 0 parabola, 1 triangle, 2 rectangle, 3 sawtooth.
REQ-013 nburst  in  8  pulses per burst; 0 = continuous until stop.
REQ-014 ka  in  16  scale factor.
REQ-015 m  in  MW  amplitude multiplier.
REQ-016 busy  out  1  high in RUN and FIN.
REQ-017 co  out  1  high while the current point is the last point of a pulse.
REQ-018 done  out  1  one-cycle pulse on burst completion.
REQ-019 sat  out  1  high when the current out value is clipped.
REQ-020 out  out  OW  scaled shape sample.

Function
REQ-021 States IDLE, RUN, FIN; every transition and every counter update requires ce=1.
REQ-022 IDLE and start=1 -> RUN: latch np, mode, nburst, ka, m; idx=0; pulse count=0; raw=0; parabola slope x=npe/2-1.
REQ-023 Effective npe = np with bit 0 cleared, then clamped to a minimum of 4.
REQ-024 Input changes while busy are ignored until the next start.
REQ-025 idx counts 0..npe-1 and wraps to 0; co=busy and (idx==npe-1).
REQ-026 Parabola: raw(idx)=idx*(npe-1-idx)/2, produced by the recurrence raw+=x, x-=1 (x signed); at wrap raw=0 and x=npe/2-1.
REQ-027 Triangle: raw=min(idx, npe-1-idx); rectangle: raw=npe/2; sawtooth: raw=idx.
REQ-028 Product p = raw*ka*m at full width (RW+16+MW bits); s = p>>SH.
REQ-029 out = s if s<2^OW, else all ones with sat=1; sat=0 otherwise.
REQ-030 out=0 and sat=0 in IDLE; out is a combinational function of registered state (zero added latency).
REQ-031 On each wrap, pulse count increments; nburst!=0 and count reaches nburst -> IDLE with done=1 on that edge.
REQ-032 stop=1 in RUN -> FIN; FIN continues to the end of the current pulse, then -> IDLE with done=1.
REQ-033 stop on the same edge as the final wrap: done=1 exactly once.
REQ-034 start while busy is ignored; start and stop together in IDLE: start wins, stop ignored.
REQ-035 done is asserted on exactly one clk cycle, is low otherwise, and is not held by ce=0.
REQ-036 With ce=0, all outputs hold their values except done.

Reset
REQ-037 rst_n=0 at an edge -> IDLE, idx=0, raw=0, count=0, busy=0, co=0, done=0, sat=0, out=0, regardless of ce.
REQ-038 Reset mid-burst aborts with no done pulse; the first start accepted after rst_n=1 begins a fresh burst.

Verification
REQ-039 np=100, mode=0, ka=6687, m=128, nburst=1, ce=1: start -> out=0 at idx 0; peak at idx 49/50 is 1225*6687*128>>18=3999; co at idx 99; done at the next edge.
REQ-040 Same settings, m=255, ka=65535: out saturates at 4095 with sat=1 around the peak; out=0 and sat=0 at idx 0.
REQ-041 np=7 -> npe=6; np=2 -> npe=4; co period matches npe; triangle raw sequence for npe=6 is 0,1,2,2,1,0.
REQ-042 nburst=0, stop asserted at idx 30 of pulse 3 -> busy until idx 99 of pulse 3, then done=1 once; a start in FIN is ignored.
REQ-043 ce toggled 1/0 on alternate cycles -> sequence is identical to the ce=1 case at half rate, and done is still one clk wide.
REQ-044 rst_n=0 at idx 40 of a burst -> all outputs 0 on the next cycle, no done; a new start produces the full REQ-039 sequence.
